// File: rtl/uart_calc_printer.sv
// UART command calculator: collects little-endian operands, multiplies them,
// and streams the decimal product (leading zeros suppressed) over the tx handshake.
`timescale 1ns/1ps
module uart_calc_printer #(
    parameter int unsigned OPERAND_BYTES = 4,
    parameter int unsigned RESULT_DIGITS = 20,
    parameter logic [7:0]  SQUARE_CMD    = 8'h68,
    parameter logic [7:0]  MULT_CMD      = 8'h6D,
    parameter logic [7:0]  ABORT_CHAR    = 8'h1B,
    parameter bit          APPEND_CRLF   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       busy,
    output logic [7:0] byte_count
);
    localparam int unsigned OW    = 8 * OPERAND_BYTES;
    localparam int unsigned PW    = 2 * OW;
    localparam int unsigned BW    = 4 * RESULT_DIGITS;
    localparam int unsigned CNT_W = $clog2(PW);
    localparam int unsigned PTR_W = (RESULT_DIGITS > 1) ? $clog2(RESULT_DIGITS) : 1;
    localparam logic [7:0]       LAST_BYTE = 8'(OPERAND_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(PW - 1);

    typedef enum logic [2:0] {IDLE, COLLECT_A, COLLECT_B, MULT, CONV, PRINT, CRLF} state_t;

    state_t             state;
    logic               sq_mode;
    logic               crlf_lf;
    logic [OW-1:0]      op_a;
    logic [OW-1:0]      op_b;
    logic [PW-1:0]      product;
    logic [BW-1:0]      bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PTR_W-1:0]   digit_ptr;

    logic [OW-1:0]      lane_a_c;
    logic [OW-1:0]      lane_b_c;
    logic [BW-1:0]      adj_c;
    logic [BW-1:0]      bcd_next_c;
    logic [PTR_W-1:0]   msd_c;
    logic [3:0]         digit_c;
    logic               can_send_c;

    // Operand values with the incoming byte placed in lane byte_count
    always_comb begin
        lane_a_c = op_a;
        lane_b_c = op_b;
        for (int i = 0; i < int'(OPERAND_BYTES); i++) begin
            if (byte_count == 8'(i)) begin
                lane_a_c[i*8 +: 8] = rx_data;
                lane_b_c[i*8 +: 8] = rx_data;
            end
        end
    end

    // Double-dabble step, MSD search on the post-step value, and digit select
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < int'(RESULT_DIGITS); i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd_next_c = {adj_c[BW-2:0], product[PW-1]};
        msd_c = '0;
        for (int i = 0; i < int'(RESULT_DIGITS); i++) begin
            if (bcd_next_c[i*4 +: 4] != 4'd0) msd_c = PTR_W'(i);
        end
        digit_c = 4'd0;
        for (int i = 0; i < int'(RESULT_DIGITS); i++) begin
            if (digit_ptr == PTR_W'(i)) digit_c = bcd[i*4 +: 4];
        end
    end

    // A strobe may only follow a cycle without one, and never while tx is busy
    assign can_send_c = !tx_busy && !new_tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sq_mode     <= 1'b0;
            crlf_lf     <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            product     <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
            digit_ptr   <= '0;
            tx_data     <= 8'd0;
            new_tx_data <= 1'b0;
            busy        <= 1'b0;
            byte_count  <= 8'd0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                IDLE: begin
                    byte_count <= 8'd0;
                    if (new_rx_data && (rx_data == SQUARE_CMD || rx_data == MULT_CMD)) begin
                        sq_mode <= (rx_data == SQUARE_CMD);
                        state   <= COLLECT_A;
                        busy    <= 1'b1;
                    end
                end
                COLLECT_A: begin
                    if (new_rx_data) begin
                        if (rx_data == ABORT_CHAR) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            byte_count <= 8'd0;
                        end else begin
                            op_a       <= lane_a_c;
                            byte_count <= byte_count + 8'd1;
                            if (byte_count == LAST_BYTE) begin
                                if (sq_mode) begin
                                    op_b  <= lane_a_c;
                                    state <= MULT;
                                end else begin
                                    byte_count <= 8'd0;
                                    state      <= COLLECT_B;
                                end
                            end
                        end
                    end
                end
                COLLECT_B: begin
                    if (new_rx_data) begin
                        if (rx_data == ABORT_CHAR) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            byte_count <= 8'd0;
                        end else begin
                            op_b       <= lane_b_c;
                            byte_count <= byte_count + 8'd1;
                            if (byte_count == LAST_BYTE) state <= MULT;
                        end
                    end
                end
                MULT: begin
                    product <= PW'(op_a) * PW'(op_b);
                    bcd     <= '0;
                    bit_cnt <= '0;
                    state   <= CONV;
                end
                CONV: begin
                    bcd     <= bcd_next_c;
                    product <= product << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        digit_ptr <= msd_c;
                        state     <= PRINT;
                    end
                end
                PRINT: begin
                    if (can_send_c) begin
                        tx_data     <= 8'h30 + {4'd0, digit_c};
                        new_tx_data <= 1'b1;
                        if (digit_ptr == '0) begin
                            crlf_lf <= 1'b0;
                            if (APPEND_CRLF) begin
                                state <= CRLF;
                            end else begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                byte_count <= 8'd0;
                            end
                        end else begin
                            digit_ptr <= digit_ptr - PTR_W'(1);
                        end
                    end
                end
                CRLF: begin
                    if (can_send_c) begin
                        new_tx_data <= 1'b1;
                        if (!crlf_lf) begin
                            tx_data <= 8'h0D;
                            crlf_lf <= 1'b1;
                        end else begin
                            tx_data    <= 8'h0A;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            byte_count <= 8'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_calc_printer.sv
// Directed bench for uart_calc_printer: commands in, decimal text out.
`timescale 1ns/1ps
module tb_uart_calc_printer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       new_rx_data = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic [7:0] byte_count;

    int total = 0;
    int bad = 0;
    int spacing_bad = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] txq[$];
    logic [7:0] cmd_q[$];

    uart_calc_printer dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .busy(busy), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Capture every strobed byte and flag back-to-back strobes
    always @(negedge clk) begin
        if (new_tx_data) begin
            txq.push_back(tx_data);
            if (prev_strobe) spacing_bad++;
        end
        prev_strobe = new_tx_data;
    end

    function automatic string to_hex(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02x", s[i])};
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_cmd();
        foreach (cmd_q[i]) send_byte(cmd_q[i]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic check_tx(input string digits, input string name);
        string got = "";
        string exp;
        exp = {digits, $sformatf("%c%c", 8'h0D, 8'h0A)};
        foreach (txq[i]) got = {got, $sformatf("%c", txq[i])};
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s tx_bytes got=%s required=%s", name, to_hex(got), to_hex(exp));
        end
    endtask

    task automatic run_and_check(input string digits, input string name);
        txq.delete();
        send_cmd();
        wait_idle(name);
        repeat (4) @(negedge clk);
        check_tx(digits, name);
        total++;
        if (byte_count !== 8'd0) begin
            bad++;
            $display("FAIL %s byte_count_after got=%0d required 0", name, byte_count);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        total += 4;
        if (tx_data !== 8'd0) begin bad++; $display("FAIL reset tx_data got=%h required 00", tx_data); end
        if (new_tx_data !== 1'b0) begin bad++; $display("FAIL reset new_tx_data got=%b required 0", new_tx_data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b required 0", busy); end
        if (byte_count !== 8'd0) begin bad++; $display("FAIL reset byte_count got=%0d required 0", byte_count); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ignore();
        txq.delete();
        send_byte(8'h41);
        send_byte(8'h1B);
        send_byte(8'h03);
        repeat (5) @(negedge clk);
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL ignore busy got=%b required 0", busy); end
        if (byte_count !== 8'd0) begin bad++; $display("FAIL ignore byte_count got=%0d required 0", byte_count); end
        if (txq.size() != 0) begin bad++; $display("FAIL ignore tx_count got=%0d required 0", txq.size()); end
    endtask

    task automatic test_square();
        cmd_q = '{8'h68, 8'h03, 8'h00, 8'h00, 8'h00};
        run_and_check("9", "square3");
    endtask

    task automatic test_mult_max();
        cmd_q = '{8'h6D, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_and_check("18446744065119617025", "mult_max");
    endtask

    task automatic test_zero();
        cmd_q = '{8'h68, 8'h00, 8'h00, 8'h00, 8'h00};
        run_and_check("0", "square0");
    endtask

    task automatic test_codes_as_data();
        // 0x68 and 0x6D as operand bytes are data: 0x6D68 * 0x68 = 28008 * 104
        cmd_q = '{8'h6D, 8'h68, 8'h6D, 8'h00, 8'h00, 8'h68, 8'h00, 8'h00, 8'h00};
        run_and_check("2912832", "codes_as_data");
    endtask

    task automatic test_tx_stall();
        bit seen = 1'b0;
        txq.delete();
        cmd_q = '{8'h6D, 8'hE8, 8'h03, 8'h00, 8'h00, 8'hE8, 8'h03, 8'h00, 8'h00};
        send_cmd();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (new_tx_data === 1'b1) begin seen = 1'b1; break; end
        end
        tx_busy = 1'b1;
        total++;
        if (!seen) begin bad++; $display("FAIL stall first_strobe_timeout seen=0 required 1"); end
        repeat (200) @(negedge clk);
        total += 2;
        if (txq.size() != 1) begin bad++; $display("FAIL stall strobes_while_busy got=%0d required 1", txq.size()); end
        if (tx_data !== 8'h31) begin bad++; $display("FAIL stall tx_data_held got=%h required 31", tx_data); end
        tx_busy = 1'b0;
        wait_idle("stall");
        repeat (4) @(negedge clk);
        check_tx("1000000", "stall");
    endtask

    task automatic test_abort();
        txq.delete();
        send_byte(8'h68);
        send_byte(8'h05);
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort busy_collect got=%b required 1", busy); end
        if (byte_count !== 8'd1) begin bad++; $display("FAIL abort byte_count_collect got=%0d required 1", byte_count); end
        send_byte(8'h1B);
        repeat (100) @(negedge clk);
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort busy_after got=%b required 0", busy); end
        if (byte_count !== 8'd0) begin bad++; $display("FAIL abort byte_count_after got=%0d required 0", byte_count); end
        if (txq.size() != 0) begin bad++; $display("FAIL abort tx_count got=%0d required 0", txq.size()); end
        cmd_q = '{8'h68, 8'h02, 8'h00, 8'h00, 8'h00};
        run_and_check("4", "after_abort");
    endtask

    task automatic test_reset_mid_print();
        bit seen = 1'b0;
        txq.delete();
        cmd_q = '{8'h6D, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_cmd();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (txq.size() >= 3 && new_tx_data === 1'b1) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL rst_mid print_timeout seen=0 required 1"); end
        #1 rst = 1'b0;
        #1;
        total += 3;
        if (new_tx_data !== 1'b0) begin bad++; $display("FAIL rst_mid new_tx_data got=%b required 0", new_tx_data); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid busy got=%b required 0", busy); end
        if (tx_data !== 8'd0) begin bad++; $display("FAIL rst_mid tx_data got=%h required 00", tx_data); end
        @(negedge clk);
        rst = 1'b1;
        cmd_q = '{8'h68, 8'h07, 8'h00, 8'h00, 8'h00};
        run_and_check("49", "after_rst");
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_square();
        test_mult_max();
        test_zero();
        test_codes_as_data();
        test_tx_stall();
        test_abort();
        test_reset_mid_print();
        total++;
        if (spacing_bad != 0) begin
            bad++;
            $display("FAIL strobe_spacing back_to_back got=%0d required 0", spacing_bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
